// File: rtl/pc_seq_pkg.sv
// Shared types and widths for the PC sequencer slice.
package pc_seq_pkg;
    localparam int PC_W  = 16;
    localparam int OFF_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;
endpackage

// File: rtl/pc_seq_ras.sv
// Return-address stack: a LIFO of DEPTH entries with a synchronous clear.
// A push while full or a pop while empty is dropped; the caller flags the error.
module pc_seq_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         CLK,
    input  logic         reset_ctrl_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] top
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign wr_idx = IW'(cnt);
    assign rd_idx = IW'(cnt - 1'b1);
    assign full   = (cnt == CW'(DEPTH));
    assign empty  = (cnt == '0);
    assign top    = mem[rd_idx];

    always_ff @(posedge CLK or negedge reset_ctrl_n) begin
        if (!reset_ctrl_n)          cnt <= '0;
        else if (clear)             cnt <= '0;
        else if (push && !full)     cnt <= cnt + 1'b1;
        else if (pop && !empty)     cnt <= cnt - 1'b1;
    end

    // Storage needs no reset: entries above cnt are never read as valid data.
    always_ff @(posedge CLK) begin
        if (!clear && push && !full) mem[wr_idx] <= push_data;
    end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALTED FSM with branch, jump, call and ret.
// Define PC_SEQ_RAS_EN to build the return-address stack and the ras_err flag.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] START_ADDR = 16'h0000,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic             CLK,
    input  logic             reset_ctrl_n,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             branch_taken,
    input  logic [OFF_W-1:0] branch_offset,
    input  logic             jump_en,
    input  logic             call,
    input  logic             ret,
    input  logic [PC_W-1:0]  jump_target,
    output logic [PC_W-1:0]  pc_out,
    output logic             pc_valid,
    output logic             done,
    output logic             ras_err
);
    seq_state_e      state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;

    assign pc_inc = pc_out + 16'd1;
    assign pc_br  = pc_out + {{(PC_W-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};

`ifdef PC_SEQ_RAS_EN
    logic            ras_push, ras_pop, ras_clr, err_set;
    logic            ras_full, ras_empty;
    logic [PC_W-1:0] ras_top;

    pc_seq_ras #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
        .CLK          (CLK),
        .reset_ctrl_n (reset_ctrl_n),
        .clear        (ras_clr),
        .push         (ras_push),
        .pop          (ras_pop),
        .push_data    (pc_inc),
        .full         (ras_full),
        .empty        (ras_empty),
        .top          (ras_top)
    );
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_out;
`ifdef PC_SEQ_RAS_EN
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clr   = 1'b0;
        err_set   = 1'b0;
`endif
        case (state)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = START_ADDR;
`ifdef PC_SEQ_RAS_EN
                    ras_clr   = 1'b1;
`endif
                end
            end
            ST_RUN: begin
                if (stall) begin
                    state_nxt = ST_RUN;
                end else if (halt) begin
                    state_nxt = ST_HALTED;
                end else if (ret) begin
`ifdef PC_SEQ_RAS_EN
                    if (ras_empty) begin
                        pc_nxt  = pc_inc;
                        err_set = 1'b1;
                    end else begin
                        pc_nxt  = ras_top;
                        ras_pop = 1'b1;
                    end
`else
                    pc_nxt = pc_inc;
`endif
                end else if (call) begin
                    pc_nxt = jump_target;
`ifdef PC_SEQ_RAS_EN
                    if (ras_full) err_set  = 1'b1;
                    else          ras_push = 1'b1;
`endif
                end else if (jump_en) begin
                    pc_nxt = jump_target;
                end else if (branch_taken) begin
                    pc_nxt = pc_br;
                end else begin
                    pc_nxt = pc_inc;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                pc_nxt    = START_ADDR;
            end
        endcase
    end

    // Status outputs are flops loaded from the next state, so they track pc_out exactly.
    always_ff @(posedge CLK or negedge reset_ctrl_n) begin
        if (!reset_ctrl_n) begin
            state    <= ST_IDLE;
            pc_out   <= START_ADDR;
            pc_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_out   <= pc_nxt;
            pc_valid <= (state_nxt == ST_RUN);
            done     <= (state_nxt == ST_HALTED);
        end
    end

`ifdef PC_SEQ_RAS_EN
    always_ff @(posedge CLK or negedge reset_ctrl_n) begin
        if (!reset_ctrl_n)  ras_err <= 1'b0;
        else if (ras_clr)   ras_err <= 1'b0;
        else if (err_set)   ras_err <= 1'b1;
    end
`else
    assign ras_err = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer; expectations follow PC_SEQ_RAS_EN.
module tb_pc_sequencer;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    typedef struct {
        logic        start, stall, halt, ret, call, jmp, br;
        logic [7:0]  off;
        logic [15:0] tgt;
        logic [15:0] epc;
        logic        ev, ed, ee;
    } vec_t;

    logic        CLK = 1'b0;
    logic        reset_ctrl_n = 1'b0;
    logic        start = 0, stall = 0, halt = 0, branch_taken = 0, jump_en = 0, call = 0, ret = 0;
    logic [7:0]  branch_offset = '0;
    logic [15:0] jump_target = '0;
    logic [15:0] pc_out;
    logic        pc_valid, done, ras_err;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    pc_sequencer #(.START_ADDR(16'h0000), .RAS_DEPTH(4)) dut (
        .CLK(CLK), .reset_ctrl_n(reset_ctrl_n), .start(start), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .jump_en(jump_en),
        .call(call), .ret(ret), .jump_target(jump_target),
        .pc_out(pc_out), .pc_valid(pc_valid), .done(done), .ras_err(ras_err)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(logic s, logic st, logic h, logic r, logic c, logic j, logic b,
                                logic [7:0] o, logic [15:0] t, logic [15:0] epc,
                                logic ev, logic ed, logic ee);
        vec_t v;
        v.start = s; v.stall = st; v.halt = h; v.ret = r; v.call = c; v.jmp = j; v.br = b;
        v.off = o; v.tgt = t; v.epc = epc; v.ev = ev; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [15:0] epc, logic ev, logic ed, logic ee);
        chk({tag, ".pc"},      pc_out,   epc);
        chk({tag, ".valid"},   16'(pc_valid), 16'(ev));
        chk({tag, ".done"},    16'(done),     16'(ed));
        chk({tag, ".ras_err"}, 16'(ras_err),  16'(ee));
    endtask

    task automatic apply(vec_t v, string tag);
        start = v.start; stall = v.stall; halt = v.halt; ret = v.ret; call = v.call;
        jump_en = v.jmp; branch_taken = v.br; branch_offset = v.off; jump_target = v.tgt;
        @(posedge CLK);
        #1;
        chk_all(tag, v.epc, v.ev, v.ed, v.ee);
    endtask

    initial begin
        //               st sl h  r  c  j  b  off    tgt       epc                     v  d  e
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,               1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0001,               1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0002,               1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0003,               1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 16'h0010, 16'h0010,               1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 8'hFC, 16'h0000, 16'h0010,               1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8'hFC, 16'h0000, 16'h000C,               1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 16'h0020, 16'h0020,               1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 16'h0100, 16'h0100,               1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0000, RAS ? 16'h0021 : 16'h0101, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 16'hFFFF, 16'hFFFF,               1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,               1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 16'h0002, 16'h0002,               1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8'hFC, 16'h0000, 16'hFFFE,               1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'hFFFF,               1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,               1, 0, RAS));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 16'h0042, 16'h0042,               1, 0, RAS));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0042,               0, 1, RAS));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 8'h04, 16'h0100, 16'h0042,               0, 1, RAS));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,               1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 8'h00, 16'h0300, 16'h0000,               0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000,               1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 8'h00, 16'h0500, 16'h0001,               1, 0, RAS));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 8'h10, 16'h0300, 16'h0300,               1, 0, RAS));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8'h7F, 16'h0000, 16'h037F,               1, 0, RAS));

        #2;
        chk_all("reset", 16'h0000, 0, 0, 0);
        #10 reset_ctrl_n = 1'b1;
        #1;
        chk_all("post_release", 16'h0000, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Overflow: halt/start clears the stack, then five calls into a depth-4 stack.
        apply(mk(0, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h037F, 0, 1, RAS), "ovf_halt");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 1, 0, 0),   "ovf_start");
        for (int k = 0; k < 5; k++)
            apply(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 16'h1000 + 16'(k), 16'h1000 + 16'(k),
                     1, 0, RAS && (k == 4)), $sformatf("call%0d", k));
        apply(mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0000, RAS ? 16'h1003 : 16'h1005, 1, 0, RAS), "ret0");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0000, RAS ? 16'h1002 : 16'h1006, 1, 0, RAS), "ret1");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0000, RAS ? 16'h1001 : 16'h1007, 1, 0, RAS), "ret2");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0000, RAS ? 16'h0001 : 16'h1008, 1, 0, RAS), "ret3");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 16'h0777, 16'h0777, 1, 0, RAS), "pre_rst");

        // Asynchronous reset between edges, then an off-edge release with start held.
        #3 reset_ctrl_n = 1'b0;
        #1;
        chk_all("async_rst", 16'h0000, 0, 0, 0);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 0), "rst_held");
        #3 reset_ctrl_n = 1'b1;
        #1;
        chk_all("rel_pre_edge", 16'h0000, 0, 0, 0);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 1, 0, 0), "rel_start");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0001, 1, 0, 0), "rel_inc");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
